tohost_monitor: RTL and testbench
=================================

TOHOST_MONITOR -- requirements
Module: tohost_monitor

Interface
REQ-001 Parameter AddrWidth, default 48, request address width in bits.
REQ-002 Parameter DataWidth, default 64, data width in bits; fixed at 64.
REQ-003 Parameter TohostAddr, default 48'h0, byte address of the tohost word; 8-byte aligned.
REQ-004 Parameter FromhostAddr, default 48'h8, byte address of the fromhost word; 8-byte aligned.
REQ-005 Parameter TimeoutCycles, default 0, watchdog limit in cycles; 0 disables the watchdog.
REQ-006 Parameter TimeoutCode, default 32'hFFFF, exit code reported on watchdog expiry.
REQ-007 clk_i  in  1  single clock; all logic on rising edge.
REQ-008 rst_i  in  1  synchronous, active-high reset.
REQ-009 req_valid_i / req_ready_o  in/out  1 each  request handshake.
REQ-010 req_addr_i  in  AddrWidth  request byte address.
REQ-011 req_write_i  in  1  1 = write, 0 = read.
REQ-012 req_wdata_i  in  64  write data.
REQ-013 req_strb_i  in  8  byte strobes.
REQ-014 rsp_valid_o  out  1  one-cycle read/write acknowledge.
REQ-015 rsp_rdata_o  out  64  read data, valid with rsp_valid_o.
REQ-016 sys_valid_o / sys_ready_i  out/in  1 each  syscall handshake to the host.
REQ-017 sys_data_o  out  64  syscall payload (tohost value).
REQ-018 fromhost_valid_i  in  1  host writes fromhost_data_i into the fromhost register this cycle.
REQ-019 fromhost_data_i  in  64  host reply value.
REQ-020 exit_valid_o  out  1  sticky; simulation has finished.
REQ-021 exit_code_o  out  32  exit code; valid while exit_valid_o is high.

Function
REQ-022 An FSM SHALL have exactly three states: IDLE, SYSCALL and EXITED.
REQ-023 A request SHALL be accepted when req_valid_i && req_ready_o; req_ready_o SHALL be 1 in IDLE and EXITED, and 0 in SYSCALL.
REQ-024 Every accepted request SHALL produce rsp_valid_o exactly one cycle later; there is no backpressure on the response.
REQ-025 A read of TohostAddr SHALL return the tohost register; a read of FromhostAddr SHALL return the fromhost register; any other address SHALL return 0.
REQ-026 A write SHALL update the addressed register byte-wise under req_strb_i; writes to other addresses SHALL be acknowledged and dropped.
REQ-027 A tohost write in IDLE with resulting value V != 0 and V[0] == 1 SHALL enter EXITED in the next cycle.
REQ-028 On that exit, exit_code_o SHALL be V[32:1] and exit_valid_o SHALL be 1.
REQ-029 A tohost write in IDLE with V != 0 and V[0] == 0 SHALL enter SYSCALL, with sys_valid_o = 1 and sys_data_o = V.
REQ-030 A tohost write with V == 0 SHALL store the value and keep the FSM in IDLE.
REQ-031 On sys_valid_o && sys_ready_i, the FSM SHALL return to IDLE and the tohost register SHALL be cleared to 0 in the same edge.
REQ-032 sys_data_o SHALL be held stable while sys_valid_o is high.
REQ-033 fromhost_valid_i SHALL take effect in any state.
REQ-034 If fromhost_valid_i coincides with a bus write to FromhostAddr, the host value SHALL win.
REQ-035 EXITED SHALL be terminal until reset; later tohost writes SHALL update the register but SHALL NOT change exit_code_o.
REQ-036 Watchdog: a 32-bit counter SHALL increment each cycle in IDLE and clear on any accepted tohost write or on leaving SYSCALL.
REQ-037 When TimeoutCycles != 0 and the counter reaches TimeoutCycles-1, the FSM SHALL enter EXITED with exit_code_o = TimeoutCode.
REQ-038 If an exit write and watchdog expiry fall in the same cycle, the write SHALL take priority.
REQ-039 The counter SHALL saturate rather than wrap.

Reset
REQ-040 rst_i SHALL put the FSM in IDLE and clear the tohost, fromhost and counter registers.
REQ-041 During and after reset, all outputs SHALL be 0 (rsp_valid_o, sys_valid_o, exit_valid_o, exit_code_o, rsp_rdata_o, sys_data_o), except req_ready_o, which SHALL be 1 after reset.
REQ-042 Reset asserted mid-syscall or after exit SHALL drop the pending response and handshake in the next cycle.

Structure
REQ-043 The state enum and a tohost_req_t / tohost_rsp_t struct pair SHALL live in the shared package tohost_pkg.
REQ-044 The watchdog SHALL be a separate sub-module, tohost_watchdog (counter, clear, enable, expire).

Verification
REQ-045 Write 64'h1 to TohostAddr -> exit_valid_o = 1 and exit_code_o = 0 two cycles after the request.
REQ-046 Write 64'h7 to TohostAddr -> exit_code_o = 3; a following write of 64'h9 leaves the code at 3.
REQ-047 Write 64'h8000 to TohostAddr -> sys_valid_o = 1 with sys_data_o = 64'h8000 and req_ready_o = 0; hold sys_ready_i low 5 cycles then pulse it -> IDLE, and a tohost read returns 0.
REQ-048 fromhost_valid_i with 64'hABCD in the same cycle as a bus write of 64'h1 to FromhostAddr -> a later read returns 64'hABCD.
REQ-049 TimeoutCycles = 100 with no writes -> exit at cycle 100 with code 32'hFFFF; a tohost write at cycle 99 prevents the timeout.
REQ-050 Assert rst_i while in SYSCALL -> next cycle sys_valid_o = 0 and req_ready_o = 1.

Source files
------------

// File: rtl/tohost_pkg.sv
`default_nettype none
// ==========================================================================
// tohost_pkg : shared types and helpers for the tohost/fromhost monitor
// Revision   : 1.0
// ==========================================================================
package tohost_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYSCALL = 2'd1,
    ST_EXITED  = 2'd2
  } tohost_state_e;

  // Request after address decode; the raw address is reduced to two hit flags.
  typedef struct packed {
    logic        write;
    logic        hit_tohost;
    logic        hit_fromhost;
    logic [63:0] wdata;
    logic [7:0]  strb;
  } tohost_req_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] rdata;
  } tohost_rsp_t;

  function automatic logic [63:0] apply_strb(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_v;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tohost_watchdog.sv
`default_nettype none
// ==========================================================================
// tohost_watchdog : saturating idle-cycle counter with a one-shot expire
// Revision        : 1.0
// ==========================================================================
module tohost_watchdog #(
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  logic [31:0] r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != '1)) begin
      r_count <= r_count + 32'd1;
    end
  end

  if (TimeoutCycles == 0) begin : g_no_timeout
    assign o_expire = 1'b0;
  end else begin : g_timeout
    assign o_expire = i_enable && (r_count == 32'(TimeoutCycles - 1));
  end

endmodule
`default_nettype wire

// File: rtl/tohost_monitor.sv
`default_nettype none
// ==========================================================================
// tohost_monitor : tohost/fromhost mailbox with syscall handshake and exit
// Revision       : 1.0
// ==========================================================================
module tohost_monitor
  import tohost_pkg::*;
#(
  parameter int unsigned            AddrWidth     = 48,
  parameter int unsigned            DataWidth     = 64,
  parameter logic [AddrWidth-1:0]   TohostAddr    = AddrWidth'(0),
  parameter logic [AddrWidth-1:0]   FromhostAddr  = AddrWidth'(8),
  parameter int unsigned            TimeoutCycles = 0,
  parameter logic [31:0]            TimeoutCode   = 32'hFFFF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic                   req_write_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [7:0]             req_strb_i,
  output logic                   rsp_valid_o,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic                   sys_valid_o,
  input  logic                   sys_ready_i,
  output logic [DataWidth-1:0]   sys_data_o,
  input  logic                   fromhost_valid_i,
  input  logic [DataWidth-1:0]   fromhost_data_i,
  output logic                   exit_valid_o,
  output logic [31:0]            exit_code_o
);

  tohost_state_e r_state;
  logic          r_ready;
  logic [63:0]   r_tohost;
  logic [63:0]   r_fromhost;
  tohost_rsp_t   r_rsp;
  logic          r_sys_valid;
  logic [63:0]   r_sys_data;
  logic          r_exit_valid;
  logic [31:0]   r_exit_code;

  tohost_req_t   w_req;
  logic          w_accept;
  logic          w_tohost_wr;
  logic          w_fromhost_wr;
  logic          w_sys_done;
  logic          w_wd_expire;
  logic [63:0]   w_to_merged;
  logic [63:0]   w_fh_merged;
  logic [63:0]   w_rd_value;

  assign w_req = '{
    write:        req_write_i,
    hit_tohost:   (req_addr_i == TohostAddr),
    hit_fromhost: (req_addr_i == FromhostAddr),
    wdata:        req_wdata_i,
    strb:         req_strb_i
  };

  assign w_accept      = req_valid_i && r_ready;
  assign w_tohost_wr   = w_accept && w_req.write && w_req.hit_tohost;
  assign w_fromhost_wr = w_accept && w_req.write && w_req.hit_fromhost;
  assign w_sys_done    = (r_state == ST_SYSCALL) && sys_ready_i;
  assign w_to_merged   = apply_strb(r_tohost, w_req.wdata, w_req.strb);
  assign w_fh_merged   = apply_strb(r_fromhost, w_req.wdata, w_req.strb);
  assign w_rd_value    = w_req.hit_tohost   ? r_tohost   :
                         w_req.hit_fromhost ? r_fromhost : 64'd0;

  tohost_watchdog #(
    .TimeoutCycles (TimeoutCycles)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_clear  (w_tohost_wr || w_sys_done),
    .i_enable (r_state == ST_IDLE),
    .o_expire (w_wd_expire)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b1;
      r_tohost     <= '0;
      r_fromhost   <= '0;
      r_rsp        <= '0;
      r_sys_valid  <= 1'b0;
      r_sys_data   <= '0;
      r_exit_valid <= 1'b0;
      r_exit_code  <= '0;
    end else begin
      r_rsp.valid <= w_accept;
      r_rsp.rdata <= (w_accept && !w_req.write) ? w_rd_value : 64'd0;

      // Host update is assigned last so it overrides a same-cycle bus write.
      if (w_fromhost_wr)    r_fromhost <= w_fh_merged;
      if (fromhost_valid_i) r_fromhost <= fromhost_data_i;

      if (w_tohost_wr) r_tohost <= w_to_merged;

      case (r_state)
        ST_IDLE: begin
          if (w_tohost_wr) begin
            if (w_to_merged != 64'd0) begin
              if (w_to_merged[0]) begin
                r_state      <= ST_EXITED;
                r_exit_valid <= 1'b1;
                r_exit_code  <= w_to_merged[32:1];
              end else begin
                r_state     <= ST_SYSCALL;
                r_ready     <= 1'b0;
                r_sys_valid <= 1'b1;
                r_sys_data  <= w_to_merged;
              end
            end
          end else if (w_wd_expire) begin
            r_state      <= ST_EXITED;
            r_exit_valid <= 1'b1;
            r_exit_code  <= TimeoutCode;
          end
        end
        ST_SYSCALL: begin
          if (sys_ready_i) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_sys_valid <= 1'b0;
            r_sys_data  <= '0;
            r_tohost    <= '0;
          end
        end
        ST_EXITED: begin
          r_state <= ST_EXITED;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o  = r_ready;
  assign rsp_valid_o  = r_rsp.valid;
  assign rsp_rdata_o  = r_rsp.rdata;
  assign sys_valid_o  = r_sys_valid;
  assign sys_data_o   = r_sys_data;
  assign exit_valid_o = r_exit_valid;
  assign exit_code_o  = r_exit_code;

endmodule
`default_nettype wire

// File: tb/tb_tohost_monitor.sv
`default_nettype none
// ==========================================================================
// tb_tohost_monitor : directed checks on a default instance and a watchdog one
// Revision          : 1.0
// ==========================================================================
module tb_tohost_monitor;

  logic        clk;
  logic        rst, rst_b;
  logic        req_valid, req_write, req_ready;
  logic [47:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_strb;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        sys_valid, sys_ready;
  logic [63:0] sys_data;
  logic        fh_valid;
  logic [63:0] fh_data;
  logic        exit_valid;
  logic [31:0] exit_code;

  logic        b_req_valid, b_req_ready, b_rsp_valid, b_sys_valid, b_exit_valid;
  logic [63:0] b_req_wdata, b_rsp_rdata, b_sys_data;
  logic [31:0] b_exit_code;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] rd;

  tohost_monitor u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .sys_valid_o(sys_valid), .sys_ready_i(sys_ready), .sys_data_o(sys_data),
    .fromhost_valid_i(fh_valid), .fromhost_data_i(fh_data),
    .exit_valid_o(exit_valid), .exit_code_o(exit_code)
  );

  tohost_monitor #(.TimeoutCycles(100)) u_dut_wd (
    .clk_i(clk), .rst_i(rst_b),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_addr_i(48'h0),
    .req_write_i(1'b1), .req_wdata_i(b_req_wdata), .req_strb_i(8'hFF),
    .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rsp_rdata),
    .sys_valid_o(b_sys_valid), .sys_ready_i(1'b0), .sys_data_o(b_sys_data),
    .fromhost_valid_i(1'b0), .fromhost_data_i(64'h0),
    .exit_valid_o(b_exit_valid), .exit_code_o(b_exit_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [47:0] a, input logic [63:0] d, input logic [7:0] s);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_strb = s;
    tick();
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [47:0] a, output logic [63:0] d);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    tick();
    req_valid = 1'b0;
    d = rsp_rdata;
  endtask

  task automatic b_reset_and_idle99();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    repeat (99) tick();
  endtask

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
    sys_ready = 1'b0; fh_valid = 1'b0; fh_data = '0;
    b_req_valid = 1'b0; b_req_wdata = '0;
    tick(); tick();

    chk("rst_rsp_valid",  rsp_valid,  0);
    chk("rst_rsp_rdata",  rsp_rdata,  0);
    chk("rst_sys_valid",  sys_valid,  0);
    chk("rst_sys_data",   sys_data,   0);
    chk("rst_exit_valid", exit_valid, 0);
    chk("rst_exit_code",  exit_code,  0);
    chk("rst_req_ready",  req_ready,  1);
    rst = 1'b0;

    // Host reply collides with a bus write to fromhost.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 48'h8; req_wdata = 64'h1; req_strb = 8'hFF;
    fh_valid = 1'b1; fh_data = 64'hABCD;
    tick();
    req_valid = 1'b0; req_write = 1'b0; fh_valid = 1'b0;
    chk("fh_wr_ack", rsp_valid, 1);
    bus_rd(48'h8, rd);
    chk("fh_rd_ack", rsp_valid, 1);
    chk("fh_host_wins", rd, 64'hABCD);

    bus_wr(48'h8, 64'h1122334455667788, 8'h0F);
    bus_rd(48'h8, rd);
    chk("fh_strb_merge", rd, 64'h0000_0000_5566_7788);
    bus_rd(48'h10, rd);
    chk("unmapped_rd", rd, 64'h0);

    bus_wr(48'h0, 64'h0, 8'hFF);
    tick();
    chk("zero_wr_ready", req_ready, 1);
    chk("zero_wr_sys",   sys_valid, 0);
    chk("zero_wr_exit",  exit_valid, 0);

    // Syscall with host stalling, and a request offered while busy.
    bus_wr(48'h0, 64'h8000, 8'hFF);
    chk("sc_valid", sys_valid, 1);
    chk("sc_data",  sys_data,  64'h8000);
    chk("sc_ready", req_ready, 0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 48'h8;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sc_hold_valid", sys_valid, 1);
      chk("sc_hold_data",  sys_data,  64'h8000);
      chk("sc_no_accept",  rsp_valid, 0);
    end
    req_valid = 1'b0;
    sys_ready = 1'b1;
    tick();
    sys_ready = 1'b0;
    chk("sc_done_valid", sys_valid, 0);
    chk("sc_done_ready", req_ready, 1);
    bus_rd(48'h0, rd);
    chk("sc_tohost_cleared", rd, 64'h0);

    bus_wr(48'h0, 64'h8000, 8'hFF);
    chk("sc2_valid", sys_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sc_rst_valid", sys_valid, 0);
    chk("sc_rst_ready", req_ready, 1);
    chk("sc_rst_data",  sys_data,  0);

    bus_wr(48'h0, 64'h1, 8'hFF);
    tick();
    chk("exit1_valid", exit_valid, 1);
    chk("exit1_code",  exit_code,  0);
    chk("exit1_ready", req_ready,  1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("exit_rst_valid", exit_valid, 0);

    bus_wr(48'h0, 64'hFFFF_FFFF_FFFF_FF05, 8'h01);
    chk("exit_strb_code", exit_code, 2);
    rst = 1'b1; tick(); rst = 1'b0;

    bus_wr(48'h0, 64'h7, 8'hFF);
    chk("exit7_code", exit_code, 3);
    bus_wr(48'h0, 64'h9, 8'hFF);
    tick();
    chk("exit_sticky_valid", exit_valid, 1);
    chk("exit_sticky_code",  exit_code,  3);
    bus_rd(48'h0, rd);
    chk("exited_tohost_upd", rd, 64'h9);

    // Watchdog instance: plain timeout.
    b_reset_and_idle99();
    chk("wd_pre_exit", b_exit_valid, 0);
    tick();
    chk("wd_exit_valid", b_exit_valid, 1);
    chk("wd_exit_code",  b_exit_code,  32'hFFFF);

    // A zero write at cycle 99 restarts the count.
    b_reset_and_idle99();
    b_req_valid = 1'b1; b_req_wdata = 64'h0;
    tick();
    b_req_valid = 1'b0;
    chk("wd_wr_ack",     b_rsp_valid,  1);
    chk("wd_prevented",  b_exit_valid, 0);
    repeat (10) tick();
    chk("wd_still_idle", b_exit_valid, 0);
    chk("wd_ready",      b_req_ready,  1);
    chk("wd_sys_valid",  b_sys_valid,  0);
    chk("wd_sys_data",   b_sys_data,   0);
    chk("wd_rsp_rdata",  b_rsp_rdata,  0);

    // Exit write coinciding with expiry wins.
    b_reset_and_idle99();
    b_req_valid = 1'b1; b_req_wdata = 64'h3;
    tick();
    b_req_valid = 1'b0;
    chk("wd_prio_valid", b_exit_valid, 1);
    chk("wd_prio_code",  b_exit_code,  1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
